// File: rtl/mm_operand_feeder_pkg.sv
// Shared constants and state encoding for the operand feeder and its skew selector.
package mm_operand_feeder_pkg;

    localparam int DATABUS     = 8;
    localparam int MM_N        = 4;
    localparam int ISSUE_LEN   = 2 * MM_N - 1;
    localparam int ISSUE_CNT_W = 3;

    localparam logic [ISSUE_CNT_W-1:0] LAST_ISSUE_T = ISSUE_CNT_W'(ISSUE_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/mm_skew_mux.sv
// Diagonal skew selector: for issue cycle t and column j it returns M[t-j][j],
// or zero when column j has not started yet or has already drained.
module mm_skew_mux
    import mm_operand_feeder_pkg::*;
#(
    parameter int DATA_W = DATABUS,
    parameter int N      = MM_N
) (
    input  logic [ISSUE_CNT_W-1:0]  i_t,
    input  logic [1:0]              i_col,
    input  logic [N*N*DATA_W-1:0]   i_rows,
    output logic [DATA_W-1:0]       o_data
);

    localparam int DIFF_W = ISSUE_CNT_W + 1;
    localparam logic [DIFF_W-1:0] ROW_COUNT = DIFF_W'(N);

    logic [DIFF_W-1:0] w_diff;
    logic              w_started;

    assign w_started = ({1'b0, i_t} >= {2'b00, i_col});
    assign w_diff    = {1'b0, i_t} - {2'b00, i_col};

    // Pick the element on the current anti-diagonal for this column, zero outside the window.
    always_comb begin
        o_data = '0;
        if (w_started && (w_diff < ROW_COUNT)) begin
            o_data = i_rows[(int'(w_diff[1:0]) * N + int'(i_col)) * DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/mm_operand_feeder.sv
// Collects a 4x4 operand matrix row by row, then streams it onto the north edge
// of a systolic array with a one-cycle-per-column diagonal skew.
module mm_operand_feeder
    import mm_operand_feeder_pkg::*;
#(
    parameter int DATA_W = DATABUS,
    parameter int N      = MM_N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [N*DATA_W-1:0] wr_row,
    input  logic                wr_conf,
    output logic                start,
    output logic                conf,
    output logic [DATA_W-1:0]   data_out0,
    output logic [DATA_W-1:0]   data_out1,
    output logic [DATA_W-1:0]   data_out2,
    output logic [DATA_W-1:0]   data_out3,
    output logic                busy,
    output logic                done
);

    feeder_state_t             r_state;
    logic [1:0]                r_rowCnt;
    logic [ISSUE_CNT_W-1:0]    r_issueT;
    logic                      r_confLatch;
    logic                      r_start;
    logic                      r_conf;
    logic                      r_busy;
    logic                      r_done;
    logic [DATA_W-1:0]         r_dataOut [N];
    logic [N*DATA_W-1:0]       r_rows [N];

    logic                      w_xfer;
    logic [ISSUE_CNT_W-1:0]    w_nextT;
    logic [N*N*DATA_W-1:0]     w_rowsFlat;
    logic [DATA_W-1:0]         w_skew [N];

    assign wr_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_xfer   = wr_valid && wr_ready;

    // The selectors look one cycle ahead so the registered outputs line up with the issue counter.
    assign w_nextT  = (r_state == ST_ISSUE) ? (r_issueT + ISSUE_CNT_W'(1)) : '0;

    assign start     = r_start;
    assign conf      = r_conf;
    assign busy      = r_busy;
    assign done      = r_done;
    assign data_out0 = r_dataOut[0];
    assign data_out1 = r_dataOut[1];
    assign data_out2 = r_dataOut[2];
    assign data_out3 = r_dataOut[3];

    // Row storage; only written on an accepted transfer, which cannot happen in ISSUE or DONE.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_rows[r_rowCnt] <= wr_row;
        end
    end

    // Flatten the stored rows so every column selector sees the whole matrix.
    always_comb begin
        w_rowsFlat = '0;
        for (int r = 0; r < N; r++) begin
            w_rowsFlat[r*N*DATA_W +: N*DATA_W] = r_rows[r];
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_col
        mm_skew_mux #(
            .DATA_W (DATA_W),
            .N      (N)
        ) u_skewMux (
            .i_t    (w_nextT),
            .i_col  (2'(j)),
            .i_rows (w_rowsFlat),
            .o_data (w_skew[j])
        );
    end

    // Load/issue sequencer with every array-facing output registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_rowCnt    <= '0;
            r_issueT    <= '0;
            r_confLatch <= 1'b0;
            r_start     <= 1'b0;
            r_conf      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int j = 0; j < N; j++) begin
                r_dataOut[j] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_confLatch <= wr_conf;
                        r_rowCnt    <= 2'd1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_rowCnt <= r_rowCnt + 2'd1;
                        if (r_rowCnt == 2'd3) begin
                            r_issueT <= '0;
                            r_start  <= 1'b1;
                            r_conf   <= r_confLatch;
                            for (int j = 0; j < N; j++) begin
                                r_dataOut[j] <= w_skew[j];
                            end
                            r_state  <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_issueT == LAST_ISSUE_T) begin
                        r_start <= 1'b0;
                        r_conf  <= 1'b0;
                        r_done  <= 1'b1;
                        for (int j = 0; j < N; j++) begin
                            r_dataOut[j] <= '0;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_issueT <= w_nextT;
                        for (int j = 0; j < N; j++) begin
                            r_dataOut[j] <= w_skew[j];
                        end
                    end
                end
                ST_DONE: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_confLatch <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mm_operand_feeder.md
MM_OPERAND_FEEDER -- requirements
Module: mm_operand_feeder

Interface
REQ-001 Parameter: DATA_W, 8, operand width; SHALL equal the width of `DATABUS in defines.v.
REQ-002 Parameter: N, 4, array dimension; only N=4 SHALL be supported.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: wr_valid  input  1  a row of operands is offered.
REQ-006 Port: wr_ready  output  1  feeder accepts a row this cycle.
REQ-007 Port: wr_row  input  N*DATA_W  row operands, element j at bits [j*DATA_W +: DATA_W].
REQ-008 Port: wr_conf  input  1  sampled with row 0; marks the matrix as a configuration (weight) load.
REQ-009 Port: start  output  1  drives array valid; high only during ISSUE.
REQ-010 Port: conf  output  1  drives array conf; equals the latched wr_conf during ISSUE, else 0.
REQ-011 Port: data_out0..data_out3  output  DATA_W each  north-edge operands for array columns 0..3.
REQ-012 Port: busy  output  1  high in any state other than IDLE.
REQ-013 Port: done  output  1  one-cycle pulse after the last issue cycle.

Function
REQ-014 States SHALL be IDLE, LOAD, ISSUE, DONE; encoding is free.
REQ-015 A row transfer SHALL occur on a rising edge with wr_valid and wr_ready both high; wr_ready SHALL be high in IDLE and LOAD only.
REQ-016 IDLE -> LOAD on the first transfer (row 0 stored, wr_conf latched); LOAD holds a 2-bit row counter.
REQ-017 The 4th transfer (row 3) SHALL move LOAD -> ISSUE on that edge; start SHALL be high on the following cycle.
REQ-018 ISSUE SHALL last exactly 7 cycles (t = 0..6) with start=1 throughout.
REQ-019 At issue cycle t, data_outj SHALL equal M[t-j][j] when 0 <= t-j <= 3, else 0 (diagonal skew; column j delayed j cycles).
REQ-020 After t=6, ISSUE -> DONE for one cycle with done=1, start=0, all data_out=0; then DONE -> IDLE.
REQ-021 Outside ISSUE, start, conf and all data_out SHALL be 0.
REQ-022 All outputs except wr_ready SHALL be driven directly from flops.
REQ-023 wr_valid while wr_ready is low SHALL be ignored with no state change; the source holds the row until accepted.
REQ-024 wr_conf SHALL be ignored on rows 1..3.
REQ-025 Row storage SHALL NOT change in ISSUE or DONE; a new matrix is accepted from IDLE on the cycle after done.
REQ-026 Operands SHALL pass unmodified: no arithmetic, sign extension or truncation.

Reset
REQ-027 rst low SHALL immediately force IDLE, row counter 0, issue counter 0, start=0, conf=0, done=0, busy=0, data_out*=0, latched conf=0.
REQ-028 Reset during LOAD or ISSUE SHALL discard the partial matrix; the issue sequence SHALL NOT resume.
REQ-029 Row storage need not be reset; it SHALL NOT be observable before a full load.

Structure
REQ-030 DATA_W, N, the issue length (2N-1) and the state encoding SHALL be in the shared defines file next to `DATABUS.
REQ-031 There SHALL be one sub-module, mm_skew_mux, a combinational selector mapping (t, j, rows) to one data_out value; it is instantiated N times.

Verification
REQ-032 Load rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} with wr_conf=0 -> after row 3, issue t0..t6: col0 = 1,5,9,13,0,0,0; col3 = 0,0,0,4,8,12,16; conf=0; done pulse at t+7.
REQ-033 Same load with wr_conf=1 on row 0 and wr_conf=0 on rows 1..3 -> conf=1 for all 7 start cycles, 0 otherwise.
REQ-034 wr_valid held high throughout ISSUE and DONE -> wr_ready=0, no transfer; the next matrix is accepted on the first IDLE cycle and its data matches REQ-019.
REQ-035 Rows 0..3 offered with wr_valid gaps of 0-3 random cycles -> issue output identical to REQ-032.
REQ-036 rst low at issue t=3 -> all outputs 0 immediately; after release busy=0, no done pulse, and a fresh load issues correctly.
REQ-037 Back-to-back matrices driven into a MatrixMultiplier instance -> result0..3 match a software 4x4 model.
